aes128_wb_regs: RTL
===================

# aes128_wb_regs

Wishbone B4 classic responder that sits between the management SoC Wishbone bus in `user_project_wrapper` and the `aes128` core. It exposes key, plaintext and ciphertext as memory-mapped 32-bit registers. It launches the core with a one-cycle start pulse and captures the core's result on its done pulse. Status is reported through a CTRL/STATUS register and an optional interrupt.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: window base; a request is decoded only when `wbs_adr_i[31:8] == BASE_ADDR[31:8]`.
- `wb_clk_i` in 1: the only clock. Every flop is clocked on its rising edge.
- `wb_rst_i` in 1: reset, synchronous and active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone strobe, cycle and write enable.
- `wbs_sel_i` in 4: byte enables for writes.
- `wbs_dat_i` in 32: write data.
- `wbs_adr_i` in 32: byte address.
- `wbs_ack_o` out 1: registered acknowledge.
- `wbs_dat_o` out 32: registered read data.
- `core_key` out 128: key to the core.
- `core_din` out 128: plaintext to the core.
- `core_start` out 1: one-cycle launch pulse to the core.
- `core_dout` in 128: result from the core.
- `core_done` in 1: one-cycle completion pulse from the core.
- `irq` out 1: level interrupt. Drives `user_irq[0]` in the wrapper.

## Operation
- Offset map (`wbs_adr_i[7:0]`), word-aligned:
  - 0x00 CTRL. Write: bit0 START, bit1 CLRDONE, bit2 IE. Read: bit0 BUSY, bit1 DONE, bit2 IE.
  - 0x10–0x1C KEY0–KEY3, R/W. KEY0 is `core_key[127:96]`; KEY3 is `[31:0]`.
  - 0x20–0x2C DIN0–DIN3, R/W, same word order.
  - 0x30–0x3C DOUT0–DOUT3, read-only, same word order.
- An unmapped offset inside the window is acknowledged: reads return 0 and writes are dropped. Writes to DOUT are dropped.
- A request outside the window is never acknowledged.
- Byte lanes: `wbs_sel_i[n]` gates byte n (`dat[8n+7:8n]`) for KEY and DIN writes. CTRL uses lane 0 only.
- States, encoded by BUSY and DONE: IDLE (0,0), RUN (1,0), DONE (0,1).
  - START=1 written in IDLE or DONE: `core_start` pulses, BUSY←1, DONE←0, next state RUN.
  - `core_done` in RUN: DOUT0–DOUT3 ← `core_dout`, BUSY←0, DONE←1, next state DONE.
  - CLRDONE=1 in DONE: DONE←0, next state IDLE.
- Rules that apply while BUSY=1:
  - START is ignored. No second `core_start` pulse is issued.
  - KEY and DIN writes are acknowledged but dropped, so `core_key` and `core_din` stay stable for the whole run.
  - IE writes still take effect.
- Simultaneous events:
  - START and CLRDONE written together: START wins.
  - `core_done` while BUSY=0 is ignored, and DOUT is unchanged.
  - `core_done` in the same cycle as a CTRL write that reaches the register: `core_done` is applied first, then the write is evaluated against the new state.
- `core_key` and `core_din` are continuous copies of the KEY and DIN registers.

## Timing
- Accept condition: `wbs_cyc_i & wbs_stb_i & in-window & ~wbs_ack_o`.
- On the edge after the accept condition is met:
  - `wbs_ack_o` goes high for exactly one cycle.
  - For reads, `wbs_dat_o` is valid in that same cycle. `wbs_dat_o` is 0 in every non-ack cycle.
  - For writes, the register update occurs on that same edge.
  - Latency is one wait state.
- The `~wbs_ack_o` term prevents a held strobe from being acknowledged twice. Back-to-back transfers therefore complete every two cycles.
- `core_start` is high in the same cycle as the acknowledge of the START write, and for that cycle only.
- DOUT, BUSY and DONE update on the edge after `core_done` is sampled high. A read accepted in the `core_done` cycle returns the updated values.
- Reset values: all registers 0, `wbs_ack_o`=0, `wbs_dat_o`=0, `core_start`=0, `irq`=0.
- Reset asserted mid-transfer drops that transfer with no acknowledge.
- Reset asserted mid-run returns the block to IDLE. A late `core_done` from the aborted run is then ignored.

## Configuration
- `AES_WB_IRQ_EN` defined:
  - CTRL bit2 IE is implemented.
  - `irq` is registered and equals DONE & IE, updating one cycle after either bit changes.
- `AES_WB_IRQ_EN` undefined:
  - The IE flop is absent. CTRL bit2 reads 0 and writes to it are dropped.
  - `irq` is tied to 0.

## Test plan
- Reset, then read CTRL at 0x3000_0000: acknowledge after 1 wait state, data 0x0, `irq`=0.
- Write KEY0–KEY3 = 0x2b7e1516, 0x28aed2a6, 0xabf71588, 0x09cf4f3c, then DIN = 0x3243f6a8, 0x885a308d, 0x313198a2, 0xe0370734, then START:
  - `core_key` and `core_din` match the written words.
  - `core_start` is a single pulse.
  - Model `core_done` with `core_dout`=0x3925841d_02dc09fb_dc118597_196a0b32; DOUT0–DOUT3 read back those words and CTRL reads 0x2.
- During RUN: write DIN0=0xFFFFFFFF and START again. DIN0 is unchanged, there is no second `core_start`, and both writes are acknowledged.
- Write KEY1=0xAABBCCDD with `wbs_sel_i`=4'b0101 over 0x11111111: KEY1 reads 0x11BB11DD.
- Out-of-window address 0x3000_0100: no acknowledge for 8 cycles. Reading offset 0x44 returns 0 with an acknowledge. Holding the strobe for 4 cycles produces exactly one acknowledge pulse.
- With `AES_WB_IRQ_EN` defined:
  - Set IE and complete a run: `irq` rises one cycle after DONE.
  - Write CLRDONE: `irq` falls.
  - Assert reset mid-run and then pulse `core_done`: state stays IDLE and `irq` stays 0.

Source files
------------

// File: rtl/aes128_wb_regs.sv
// aes128_wb_regs: Wishbone B4 classic register front-end for the aes128 core.
// Holds KEY/DIN/DOUT words, launches the core with a one-cycle start pulse
// and captures its result on the done pulse.
// Optional feature macro: AES_WB_IRQ_EN (CTRL.IE flop and registered irq).
module aes128_wb_regs #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic           wb_clk_i,
   input  logic           wb_rst_i,
   input  logic           wbs_stb_i,
   input  logic           wbs_cyc_i,
   input  logic           wbs_we_i,
   input  logic [3:0]     wbs_sel_i,
   input  logic [31:0]    wbs_dat_i,
   input  logic [31:0]    wbs_adr_i,
   output logic           wbs_ack_o,
   output logic [31:0]    wbs_dat_o,
   output logic [127:0]   core_key,
   output logic [127:0]   core_din,
   output logic           core_start,
   input  logic [127:0]   core_dout,
   input  logic           core_done,
   output logic           irq
);

   // State value doubles as CTRL read bits {DONE, BUSY}.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   state_e      state_q, state_d, state_mid;
   logic [31:0] key_q [4];
   logic [31:0] key_d [4];
   logic [31:0] din_q [4];
   logic [31:0] din_d [4];
   logic [31:0] dout_q[4];
   logic [31:0] dout_d[4];
   logic        ack_q, start_q, start_d;
   logic [31:0] dat_q, dat_d, rdata;
   logic        ie_q, ie_d;

   logic        accept, wr, done_evt, ctrl_wr, busy;
   logic [7:0]  off;
   logic [1:0]  widx;
   logic        sel_ctrl, sel_key, sel_din, sel_dout;

   assign off      = wbs_adr_i[7:0];
   assign widx     = off[3:2];
   assign accept   = wbs_cyc_i & wbs_stb_i & ~ack_q &
                     (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign wr       = accept & wbs_we_i;
   assign sel_ctrl = (off == 8'h00);
   assign sel_key  = (off[7:4] == 4'h1) & (off[1:0] == 2'b00);
   assign sel_din  = (off[7:4] == 4'h2) & (off[1:0] == 2'b00);
   assign sel_dout = (off[7:4] == 4'h3) & (off[1:0] == 2'b00);
   assign ctrl_wr  = wr & sel_ctrl & wbs_sel_i[0];
   assign busy     = (state_q == ST_RUN);
   assign done_evt = core_done & busy;

   // Merge write data into a word under the byte-lane enables.
   function automatic logic [31:0] merge(input logic [31:0] old_w,
                                         input logic [31:0] new_w,
                                         input logic [3:0]  sel);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++)
         if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
      return res;
   endfunction

   // Next state: core_done resolves first, then any CTRL write sees the result.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      state_mid = done_evt ? ST_DONE : state_q;
      state_d   = state_mid;
      start_d   = 1'b0;
      if (ctrl_wr) begin
         if (wbs_dat_i[0] && state_mid != ST_RUN) begin
            state_d = ST_RUN;
            start_d = 1'b1;
         end else if (wbs_dat_i[1] && state_mid == ST_DONE) begin
            state_d = ST_IDLE;
         end
      end
   end

   // Data registers: KEY/DIN frozen while busy, DOUT captured on a valid done.
   always_comb begin
      key_d  = key_q;
      din_d  = din_q;
      dout_d = dout_q;
      if (done_evt)
         for (int i = 0; i < 4; i++) dout_d[i] = core_dout[127-32*i -: 32];
      if (wr && !busy) begin
         if (sel_key) key_d[widx] = merge(key_q[widx], wbs_dat_i, wbs_sel_i);
         if (sel_din) din_d[widx] = merge(din_q[widx], wbs_dat_i, wbs_sel_i);
      end
   end

`ifdef AES_WB_IRQ_EN
   // IE follows any CTRL write, busy or not.
   always_comb begin
      ie_d = ie_q;
      if (ctrl_wr) ie_d = wbs_dat_i[2];
   end
`else
   assign ie_d = 1'b0;
`endif

   // Read mux reflects a same-cycle core_done so reads see the updated state.
   always_comb begin
      rdata = 32'd0;
      if (sel_ctrl)      rdata = {29'd0, ie_q, state_mid};
      else if (sel_key)  rdata = key_q[widx];
      else if (sel_din)  rdata = din_q[widx];
      else if (sel_dout) rdata = dout_d[widx];
      dat_d = (accept && !wbs_we_i) ? rdata : 32'd0;
   end

   // All state registers with synchronous active-high reset.
   always_ff @(posedge wb_clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
         dat_q   <= 32'd0;
         start_q <= 1'b0;
         ie_q    <= 1'b0;
         // NOTE: these small register arrays are flops, not RAM, so they take the reset value too.
         for (int i = 0; i < 4; i++) begin
            key_q[i]  <= 32'd0;
            din_q[i]  <= 32'd0;
            dout_q[i] <= 32'd0;
         end
      end else begin
         state_q <= state_d;
         ack_q   <= accept;
         dat_q   <= dat_d;
         start_q <= start_d;
         ie_q    <= ie_d;
         key_q   <= key_d;
         din_q   <= din_d;
         dout_q  <= dout_d;
      end
   end

`ifdef AES_WB_IRQ_EN
   logic irq_q;
   // Level interrupt, one cycle behind DONE and IE.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) irq_q <= 1'b0;
      else          irq_q <= (state_q == ST_DONE) & ie_q;
   end
   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   assign wbs_ack_o  = ack_q;
   assign wbs_dat_o  = dat_q;
   assign core_start = start_q;
   assign core_key   = {key_q[0], key_q[1], key_q[2], key_q[3]};
   assign core_din   = {din_q[0], din_q[1], din_q[2], din_q[3]};

endmodule
